// File: rtl/decode_issue_queue.sv
// In-order decode/issue queue: DEPTH decoded instructions wait here, only the head may issue.
// Faulted or illegal heads raise a registered exception pulse and stay blocked until flushed.
module decode_issue_queue #(
  parameter int DEPTH       = 4,
  parameter int NUM_UNITS   = 8,
  parameter int READ_PORTS  = 2,
  parameter int PHYS_ADDR_W = 6,
  parameter int ID_W        = 3,
  parameter int PAYLOAD_W   = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              decode_valid,
  output logic                              decode_advance,
  input  logic [NUM_UNITS-1:0]              decode_unit_needed,
  input  logic [READ_PORTS-1:0]             decode_uses_rs,
  input  logic [READ_PORTS*PHYS_ADDR_W-1:0] decode_phys_rs,
  input  logic                              decode_uses_rd,
  input  logic [ID_W-1:0]                   decode_id,
  input  logic                              decode_fetch_ok,
  input  logic [PAYLOAD_W-1:0]              decode_payload,
  output logic [READ_PORTS*PHYS_ADDR_W-1:0] head_phys_rs,
  input  logic [READ_PORTS-1:0]             rs_inuse,
  input  logic [NUM_UNITS-1:0]              unit_ready,
  input  logic                              issue_hold,
  input  logic                              fetch_flush,
  output logic [NUM_UNITS-1:0]              new_request,
  output logic                              instruction_issued,
  output logic                              instruction_issued_with_rd,
  output logic [ID_W-1:0]                   issue_id,
  output logic [PAYLOAD_W-1:0]              issue_payload,
  output logic                              issue_stage_valid,
  output logic [$clog2(DEPTH):0]            occupancy,
  output logic                              exception_valid,
  output logic                              exception_illegal
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RS_W  = READ_PORTS * PHYS_ADDR_W;

  logic [NUM_UNITS-1:0]  r_unit    [DEPTH];
  logic [READ_PORTS-1:0] r_uses_rs [DEPTH];
  logic [RS_W-1:0]       r_phys_rs [DEPTH];
  logic [ID_W-1:0]       r_id      [DEPTH];
  logic [PAYLOAD_W-1:0]  r_payload [DEPTH];
  logic [DEPTH-1:0]      r_uses_rd;
  logic [DEPTH-1:0]      r_exc;
  logic [DEPTH-1:0]      r_illegal;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_exc_valid;
  logic             r_exc_illegal;

  logic w_nonempty;
  logic w_op_ok;
  logic w_unit_hit;
  logic w_go;
  logic w_new_exc;
  logic w_enq;
  logic w_in_illegal;
  logic w_in_exc;

  assign w_in_illegal = ~|decode_unit_needed;
  assign w_in_exc     = w_in_illegal | ~decode_fetch_ok;

  assign w_nonempty = (r_count != '0);
  assign w_op_ok    = &(~(r_uses_rs[r_head] & rs_inuse));
  assign w_unit_hit = |(r_unit[r_head] & unit_ready);
  assign w_go       = w_nonempty & ~r_exc[r_head] & w_op_ok & ~issue_hold
                    & ~fetch_flush & w_unit_hit;
  assign w_new_exc  = w_nonempty & r_exc[r_head] & ~issue_hold & ~fetch_flush
                    & ~r_exc_valid;
  // A full queue still accepts when the head leaves in the same cycle.
  assign w_enq      = decode_valid & ~fetch_flush
                    & ((r_count < CNT_W'(DEPTH)) | w_go);

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_unit[r_tail]    <= decode_unit_needed;
      r_uses_rs[r_tail] <= decode_uses_rs;
      r_phys_rs[r_tail] <= decode_phys_rs;
      r_id[r_tail]      <= decode_id;
      r_payload[r_tail] <= decode_payload;
      r_uses_rd[r_tail] <= decode_uses_rd;
      r_exc[r_tail]     <= w_in_exc;
      r_illegal[r_tail] <= w_in_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_exc_valid   <= 1'b0;
      r_exc_illegal <= 1'b0;
    end else begin
      r_exc_valid <= w_new_exc;
      if (w_new_exc) r_exc_illegal <= r_illegal[r_head];
      if (fetch_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= r_head + PTR_W'(w_go);
        r_tail  <= r_tail + PTR_W'(w_enq);
        r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_go);
      end
    end
  end

  assign decode_advance             = w_enq;
  assign head_phys_rs               = r_phys_rs[r_head];
  assign new_request                = r_unit[r_head] & {NUM_UNITS{w_go}};
  assign instruction_issued         = w_go;
  assign instruction_issued_with_rd = w_go & r_uses_rd[r_head];
  assign issue_id                   = r_id[r_head];
  assign issue_payload              = r_payload[r_head];
  assign issue_stage_valid          = w_nonempty;
  assign occupancy                  = r_count;
  assign exception_valid            = r_exc_valid;
  assign exception_illegal          = r_exc_illegal;
endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
- Parametrised successor to the single-entry decode/issue stage register.
- Holds up to DEPTH decoded instructions in an in-order queue between decode and the execution units.
- Only the head entry is eligible to issue. It issues when its target unit is ready, its source operands are not in use, and no hold or flush is active.
- Illegal or fetch-faulted instructions are reported as a registered pre-issue exception when they reach the head.

Parameters:
DEPTH, 4, number of queue entries (power of two, >=2)
NUM_UNITS, 8, number of execution units (one-hot unit select)
READ_PORTS, 2, source operands per instruction
PHYS_ADDR_W, 6, physical register address width
ID_W, 3, instruction id width
PAYLOAD_W, 64, opaque payload {pc, instruction}, carried unchanged

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
decode_valid  in  1  decode holds a valid instruction
decode_advance  out  1  instruction accepted into the queue this cycle
decode_unit_needed  in  NUM_UNITS  one-hot target unit; all-zero = illegal instruction
decode_uses_rs  in  READ_PORTS  operand i is read
decode_phys_rs  in  READ_PORTS*PHYS_ADDR_W  renamed source addresses
decode_uses_rd  in  1  writes a destination
decode_id  in  ID_W  instruction id
decode_fetch_ok  in  1  0 = fetch fault travels with the instruction
decode_payload  in  PAYLOAD_W  pc/instruction
head_phys_rs  out  READ_PORTS*PHYS_ADDR_W  head source addresses, to the register-file scoreboard
rs_inuse  in  READ_PORTS  scoreboard: head operand i not yet written back
unit_ready  in  NUM_UNITS  unit can accept a request
issue_hold  in  1  global issue hold
fetch_flush  in  1  squash all queued instructions
new_request  out  NUM_UNITS  one-hot issue strobe
instruction_issued  out  1  OR of new_request
instruction_issued_with_rd  out  1  issued and head uses rd
issue_id  out  ID_W  head id
issue_payload  out  PAYLOAD_W  head payload
issue_stage_valid  out  1  queue non-empty
occupancy  out  $clog2(DEPTH)+1  valid entry count
exception_valid  out  1  registered one-cycle pre-issue exception pulse
exception_illegal  out  1  1 = illegal pattern, 0 = fetch fault (valid with exception_valid)

Behaviour:
- Reset (rst_n low, async): head, tail and count = 0; exception_valid = 0.
  - All strobes are derived from count, so they read 0 while in reset.
  - Entry storage is not reset.
- Entry fields: unit_needed, uses_rs, phys_rs, uses_rd, id, payload, exc = (unit_needed==0) | ~fetch_ok, illegal = (unit_needed==0).
- Enqueue: decode_advance = decode_valid & ~fetch_flush & ((count<DEPTH) | instruction_issued).
  - Combinational full-queue bypass: the dequeue and enqueue happen in the same cycle.
  - Write goes to tail; tail wraps modulo DEPTH.
- Operand ready: op_ok = &(~(head.uses_rs & rs_inuse)).
- Issue:
  - go = (count!=0) & ~head.exc & op_ok & ~issue_hold & ~fetch_flush & |(head.unit_needed & unit_ready).
  - new_request = head.unit_needed & {NUM_UNITS{go}}.
  - instruction_issued = go; head advances on go.
- Count update: count' = count + enq - deq. Simultaneous enqueue and dequeue leave count unchanged, including when full or at count==1.
- Flush: next cycle count=0, head=tail=0; no enqueue in the flush cycle; exception_valid not raised in the flush cycle.
- Exception:
  - new_exc = (count!=0) & head.exc & ~issue_hold & ~fetch_flush & ~exception_valid.
  - exception_valid <= new_exc, so it pulses at most every other cycle.
  - The head stays blocked (no issue) until fetch_flush clears it.
- Empty queue: all issue strobes 0; issue_payload/issue_id are don't-care.
- Latency: decode to earliest issue is 1 cycle (enqueue at edge N, issue combinational in cycle N+1).
- Reset asserted mid-operation: queue contents discarded immediately.

Test Plan:
1. Reset, then decode_valid with unit_needed=8'h01, unit_ready=8'hFF, rs_inuse=0 -> decode_advance=1; next cycle new_request=8'h01, issue_id=decode_id, occupancy returns to 0.
2. unit_ready=0, four back-to-back enqueues (DEPTH=4) -> occupancy=4 and the fifth decode_advance=0. Raise unit_ready[0] -> the same cycle shows new_request=8'h01 and decode_advance=1; occupancy stays 4.
3. Head uses_rs=2'b01 with rs_inuse=2'b01 for 3 cycles -> no issue for 3 cycles. rs_inuse=2'b10 with uses_rs=2'b01 -> issues.
4. Head with unit_needed=0 -> exception_valid=1 for exactly 1 cycle with exception_illegal=1, then 0; no new_request. fetch_flush -> occupancy=0 next cycle.
5. Three entries queued plus fetch_flush while decode_valid=1 -> decode_advance=0, new_request=0; occupancy=0 next cycle.
6. Wrap-around: 10 enqueues, each issued one cycle later -> issue_id sequence matches decode_id order 0..9 mod 2^ID_W.
